// File: rtl/riscv_mem_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package riscv_mem_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    IF_XFER,
    D_XFER,
    RESP
  } arb_state_e;

endpackage

// File: rtl/mem_arb_fair_counter.sv
// Saturating count of data grants issued while a fetch was waiting; force_if_o
// tells the arbiter to let the fetch through once the limit is reached.
module mem_arb_fair_counter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  localparam int unsigned CNT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             grant_d_i,
  input  logic             grant_if_i,
  input  logic             if_req_i,
  output logic             force_if_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_if_i) begin
      cnt_d = '0;
    end else if (grant_d_i) begin
      if (!if_req_i) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_W'(STARVE_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign force_if_o = (cnt_q == CNT_W'(STARVE_MAX));
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one registered single-port memory
// request, with starvation protection for fetch and branch-kill of fetches.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_kill_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_ack_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_if_o,
  output logic                stall_mem_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                is_data_q, is_data_d;
  logic                kill_q, kill_d;
  logic                grant_if, grant_d, force_if;
  logic [CNT_W-1:0]    starve_cnt;

  mem_arb_fair_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_fair (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .grant_d_i  (grant_d),
    .grant_if_i (grant_if),
    .if_req_i   (if_req_i),
    .force_if_o (force_if),
    .cnt_o      (starve_cnt)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    is_data_d   = is_data_q;
    kill_d      = kill_q;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (d_req_i && !(if_req_i && force_if)) begin
          grant_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_be_d    = d_be_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          is_data_d   = 1'b1;
          state_d     = D_XFER;
        end else if (if_req_i) begin
          grant_if    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          is_data_d   = 1'b0;
          state_d     = IF_XFER;
        end
      end
      IF_XFER: begin
        if (if_kill_i) kill_d = 1'b1;
        if (mem_ready_i) begin
          rdata_d   = mem_rdata_i;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      D_XFER: begin
        if (mem_ready_i) begin
          rdata_d   = mem_we_q ? '0 : mem_rdata_i;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      is_data_q   <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      is_data_q   <= is_data_d;
      kill_q      <= kill_d;
    end
  end

  // A kill arriving during the ack cycle itself masks the fetch ack combinationally.
  assign if_ack_o    = (state_q == RESP) && !is_data_q && !kill_q && !if_kill_i;
  assign d_ack_o     = (state_q == RESP) && is_data_q;
  assign if_rdata_o  = rdata_q;
  assign d_rdata_o   = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_if_o  = if_req_i & ~if_ack_o;
  assign stall_mem_o = d_req_i & ~d_ack_o;

endmodule
